// File: rtl/neuron_register_bank.sv
// neuron_register_bank: coefficient/offset/input register bank and the
// start/busy/done sequencer for the neuron core.
// Build option: define NRB_READBACK_EN to add the registered read-back mux
// and clear-on-read of the status sticky bits.
module neuron_register_bank #(
   parameter int              N_COEFF     = 20,
   parameter int              DATA_W      = 16,
   parameter int              ADDR_W      = 9,
   parameter logic [ADDR_W-1:0] COEFF_BASE  = 9'h00C,
   parameter logic [ADDR_W-1:0] START_ADDR  = 9'h08C,
   parameter logic [ADDR_W-1:0] STATUS_ADDR = 9'h090
) (
   input  logic                      Clock,
   input  logic                      Reset_n,
   input  logic [ADDR_W-1:0]         Address,
   input  logic                      Write,
   input  logic                      Read,
   input  logic [DATA_W-1:0]         WriteData,
   output logic [DATA_W-1:0]         ReadData,
   output logic                      ReadValid,
   output logic [N_COEFF*DATA_W-1:0] CoeffBus,
   output logic [DATA_W-1:0]         Offset,
   output logic [DATA_W-1:0]         Entrada,
   output logic                      Start,
   input  logic                      Done,
   output logic                      Busy,
   output logic                      WrErr
);

   localparam int IDX_W = ADDR_W - 2;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_RUN   = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [DATA_W-1:0] coeff_q [N_COEFF];
   logic [DATA_W-1:0] coeff_d [N_COEFF];
   logic [DATA_W-1:0] offset_q, offset_d;
   logic [DATA_W-1:0] entrada_q, entrada_d;
   logic              start_q, start_d;
   logic              busy_q, busy_d;
   logic              done_sticky_q, done_sticky_d;
   logic              wr_err_q, wr_err_d;
   logic [DATA_W-1:0] read_data_q, read_data_d;
   logic              read_valid_q, read_valid_d;

   logic [IDX_W-1:0]  word_idx_s;
   logic              in_range_s;
   logic              is_idle_s;
   logic              data_wr_s;
   logic              start_cmd_s;
   logic              start_acc_s;
   logic              err_set_s;
   logic              done_set_s;
   logic              status_rd_s;
   logic [DATA_W-1:0] status_s;

   // Address decode and the handshake events seen at this edge.
   always_comb begin
      word_idx_s  = IDX_W'((Address - COEFF_BASE) >> 2);
      in_range_s  = (Address[1:0] == 2'b00) && (Address >= COEFF_BASE) &&
                    (word_idx_s < IDX_W'(N_COEFF + 2));
      is_idle_s   = (state_q == ST_IDLE);
      data_wr_s   = Write && in_range_s;
      start_cmd_s = Write && (Address == START_ADDR) && WriteData[0];
      start_acc_s = start_cmd_s && is_idle_s;
      // Any data or start write while a computation is in flight is a protocol error.
      err_set_s   = (!is_idle_s) && (data_wr_s || start_cmd_s);
      done_set_s  = (state_q == ST_RUN) && Done;
      status_s    = {{(DATA_W-3){1'b0}}, wr_err_q, done_sticky_q, busy_q};
`ifdef NRB_READBACK_EN
      status_rd_s = Read && (Address == STATUS_ADDR);
`else
      status_rd_s = 1'b0;
`endif
   end

   // Sequencer next state; Done outside RUN is ignored.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (start_acc_s) begin
               state_d = ST_START;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_START: state_d = ST_RUN;
         ST_RUN: begin
            if (Done) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_RUN;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      start_d = (state_d == ST_START);
      busy_d  = (state_d != ST_IDLE);
   end

   // Data register loads, accepted only while idle so the core sees stable values.
   always_comb begin
      offset_d  = offset_q;
      entrada_d = entrada_q;
      for (int i = 0; i < N_COEFF; i++) begin
         if (data_wr_s && is_idle_s && (word_idx_s == IDX_W'(i))) begin
            coeff_d[i] = WriteData;
         end else begin
            coeff_d[i] = coeff_q[i];
         end
      end
      if (data_wr_s && is_idle_s && (word_idx_s == IDX_W'(N_COEFF))) begin
         offset_d = WriteData;
      end else begin
         offset_d = offset_q;
      end
      if (data_wr_s && is_idle_s && (word_idx_s == IDX_W'(N_COEFF + 1))) begin
         entrada_d = WriteData;
      end else begin
         entrada_d = entrada_q;
      end
   end

   // Sticky status bits: a set on the same edge as a clear takes priority.
   always_comb begin
      done_sticky_d = done_sticky_q;
      wr_err_d      = wr_err_q;
      if (done_set_s) begin
         done_sticky_d = 1'b1;
      end else if (start_acc_s || status_rd_s) begin
         done_sticky_d = 1'b0;
      end else begin
         done_sticky_d = done_sticky_q;
      end
      if (err_set_s) begin
         wr_err_d = 1'b1;
      end else if (start_acc_s || status_rd_s) begin
         wr_err_d = 1'b0;
      end else begin
         wr_err_d = wr_err_q;
      end
   end

`ifdef NRB_READBACK_EN
   // Read-back mux; returns pre-write values, unmapped addresses read as zero.
   always_comb begin
      read_valid_d = Read;
      read_data_d  = {DATA_W{1'b0}};
      if (Read && (Address == STATUS_ADDR)) begin
         read_data_d = status_s;
      end else if (Read && in_range_s) begin
         for (int i = 0; i < N_COEFF; i++) begin
            if (word_idx_s == IDX_W'(i)) begin
               read_data_d = coeff_q[i];
            end else begin
               read_data_d = read_data_d;
            end
         end
         if (word_idx_s == IDX_W'(N_COEFF)) begin
            read_data_d = offset_q;
         end else if (word_idx_s == IDX_W'(N_COEFF + 1)) begin
            read_data_d = entrada_q;
         end else begin
            read_data_d = read_data_d;
         end
      end else begin
         read_data_d = {DATA_W{1'b0}};
      end
   end
`else
   logic read_unused_s;
   logic [DATA_W-1:0] status_unused_s;
   assign read_unused_s   = Read;
   assign status_unused_s = status_s;

   // Without read-back the read port is tied off.
   always_comb begin
      read_valid_d = 1'b0;
      read_data_d  = {DATA_W{1'b0}};
   end
`endif

   // State and storage flops with synchronous active-low reset.
   always_ff @(posedge Clock) begin
      if (!Reset_n) begin
         state_q       <= ST_IDLE;
         for (int i = 0; i < N_COEFF; i++) begin
            coeff_q[i] <= {DATA_W{1'b0}};
         end
         offset_q      <= {DATA_W{1'b0}};
         entrada_q     <= {DATA_W{1'b0}};
         start_q       <= 1'b0;
         busy_q        <= 1'b0;
         done_sticky_q <= 1'b0;
         wr_err_q      <= 1'b0;
         read_data_q   <= {DATA_W{1'b0}};
         read_valid_q  <= 1'b0;
      end else begin
         state_q       <= state_d;
         for (int i = 0; i < N_COEFF; i++) begin
            coeff_q[i] <= coeff_d[i];
         end
         offset_q      <= offset_d;
         entrada_q     <= entrada_d;
         start_q       <= start_d;
         busy_q        <= busy_d;
         done_sticky_q <= done_sticky_d;
         wr_err_q      <= wr_err_d;
         read_data_q   <= read_data_d;
         read_valid_q  <= read_valid_d;
      end
   end

   // Flatten the coefficient array onto the core-facing bus.
   always_comb begin
      for (int i = 0; i < N_COEFF; i++) begin
         CoeffBus[i*DATA_W +: DATA_W] = coeff_q[i];
      end
   end

   assign Offset    = offset_q;
   assign Entrada   = entrada_q;
   assign Start     = start_q;
   assign Busy      = busy_q;
   assign WrErr     = wr_err_q;
   assign ReadData  = read_data_q;
   assign ReadValid = read_valid_q;

endmodule

// File: tb/tb_neuron_register_bank.sv
// Self-checking bench for neuron_register_bank (default parameters).
module tb_neuron_register_bank;
   localparam int N  = 20;
   localparam int DW = 16;

   logic          Clock = 1'b0;
   logic          Reset_n = 1'b0;
   logic [8:0]    Address = 9'd0;
   logic          Write = 1'b0;
   logic          Read = 1'b0;
   logic [DW-1:0] WriteData = 16'd0;
   logic          Done = 1'b0;
   logic [DW-1:0] ReadData;
   logic          ReadValid;
   logic [N*DW-1:0] CoeffBus;
   logic [DW-1:0] Offset;
   logic [DW-1:0] Entrada;
   logic          Start;
   logic          Busy;
   logic          WrErr;

   int errors = 0;
   int checks = 0;

   // reference model state
   logic [DW-1:0] m_coeff [N];
   logic [DW-1:0] m_offset, m_entrada, m_rdata;
   bit m_rvalid, m_start, m_busy, m_done, m_err;

   neuron_register_bank dut (
      .Clock(Clock), .Reset_n(Reset_n), .Address(Address), .Write(Write),
      .Read(Read), .WriteData(WriteData), .ReadData(ReadData),
      .ReadValid(ReadValid), .CoeffBus(CoeffBus), .Offset(Offset),
      .Entrada(Entrada), .Start(Start), .Done(Done), .Busy(Busy), .WrErr(WrErr)
   );

   always #5 Clock = ~Clock;

   // word index for a byte address: 0..N-1 coeff, N offset, N+1 input, -1 none
   function automatic int map_idx(input int a);
      int w;
      if ((a % 4) != 0 || a < 12) return -1;
      w = (a - 12) / 4;
      if (w < N + 2) return w;
      return -1;
   endfunction

   task automatic model_edge(input int a, input bit we, input logic [DW-1:0] wd,
                             input bit rd, input bit dn, input bit rst_n);
      int w;
      bit idle, run, start_cmd, start_acc, err_set, done_set, status_rd;
      if (!rst_n) begin
         for (int i = 0; i < N; i++) m_coeff[i] = 16'd0;
         m_offset = 16'd0; m_entrada = 16'd0; m_rdata = 16'd0;
         m_rvalid = 1'b0; m_start = 1'b0; m_busy = 1'b0; m_done = 1'b0; m_err = 1'b0;
         return;
      end
      idle      = !m_busy;
      run       = m_busy && !m_start;
      w         = map_idx(a);
      start_cmd = we && (a == 140) && wd[0];
      start_acc = start_cmd && idle;
      err_set   = !idle && we && (w >= 0 || start_cmd);
      done_set  = run && dn;
      status_rd = 1'b0;
`ifdef NRB_READBACK_EN
      m_rvalid = rd;
      m_rdata  = 16'd0;
      if (rd && a == 144) begin
         m_rdata   = {13'd0, m_err, m_done, m_busy};
         status_rd = 1'b1;
      end else if (rd && w >= 0) begin
         if (w < N) m_rdata = m_coeff[w];
         else if (w == N) m_rdata = m_offset;
         else m_rdata = m_entrada;
      end
`else
      m_rvalid = 1'b0;
      m_rdata  = 16'd0;
`endif
      if (we && idle && w >= 0) begin
         if (w < N) m_coeff[w] = wd;
         else if (w == N) m_offset = wd;
         else m_entrada = wd;
      end
      if (start_acc || status_rd) begin m_done = 1'b0; m_err = 1'b0; end
      if (done_set) m_done = 1'b1;
      if (err_set) m_err = 1'b1;
      m_start = start_acc;
      if (start_acc) m_busy = 1'b1;
      else if (done_set) m_busy = 1'b0;
   endtask

   // drive one cycle of inputs, clock it, advance the model, settle
   task automatic tick(input int a, input bit we, input logic [DW-1:0] wd,
                       input bit rd, input bit dn);
      Address = a[8:0]; Write = we; WriteData = wd; Read = rd; Done = dn;
      @(posedge Clock);
      model_edge(a, we, wd, rd, dn, Reset_n);
      #1;
      Write = 1'b0; Read = 1'b0; Done = 1'b0;
   endtask

   task automatic idle_tick();
      tick(0, 1'b0, 16'd0, 1'b0, 1'b0);
   endtask

   task automatic test_reset();
      Reset_n = 1'b0;
      idle_tick(); idle_tick();
      Reset_n = 1'b1;
      checks++; if (CoeffBus !== '0) begin errors++; $display("FAIL reset_coeff got=%h exp=0", CoeffBus); end
      checks++; if ({Offset, Entrada} !== 32'd0) begin errors++; $display("FAIL reset_off_in got=%h/%h exp=0", Offset, Entrada); end
      checks++; if ({Start, Busy, WrErr, ReadValid} !== 4'd0) begin errors++; $display("FAIL reset_flags got=%b%b%b%b exp=0000", Start, Busy, WrErr, ReadValid); end
      checks++; if (ReadData !== 16'd0) begin errors++; $display("FAIL reset_rdata got=%h exp=0", ReadData); end
   endtask

   task automatic test_writes();
      tick(12, 1'b1, 16'h1234, 1'b0, 1'b0);
      checks++; if (CoeffBus[15:0] !== 16'h1234) begin errors++; $display("FAIL wr_coeff0 got=%h exp=1234", CoeffBus[15:0]); end
      tick(96, 1'b1, 16'hABCD, 1'b0, 1'b0);
      checks++; if (Entrada !== 16'hABCD) begin errors++; $display("FAIL wr_entrada got=%h exp=abcd", Entrada); end
      checks++; if (CoeffBus[N*DW-1:16] !== '0 || Offset !== 16'd0) begin errors++; $display("FAIL wr_others got=%h off=%h exp=0", CoeffBus[N*DW-1:16], Offset); end
      checks++; if ({Start, Busy, WrErr} !== 3'd0) begin errors++; $display("FAIL wr_flags got=%b%b%b exp=000", Start, Busy, WrErr); end
   endtask

   task automatic test_start_done();
      tick(140, 1'b1, 16'd1, 1'b0, 1'b0);
      checks++; if ({Start, Busy} !== 2'b11) begin errors++; $display("FAIL sd_start got=%b%b exp=11", Start, Busy); end
      idle_tick();
      checks++; if ({Start, Busy} !== 2'b01) begin errors++; $display("FAIL sd_pulse got=%b%b exp=01", Start, Busy); end
      for (int i = 0; i < 8; i++) begin
         idle_tick();
         checks++; if ({Start, Busy} !== 2'b01) begin errors++; $display("FAIL sd_busy cyc=%0d got=%b%b exp=01", i, Start, Busy); end
      end
      tick(0, 1'b0, 16'd0, 1'b0, 1'b1);
      checks++; if ({Start, Busy} !== 2'b00) begin errors++; $display("FAIL sd_done got=%b%b exp=00", Start, Busy); end
   endtask

   task automatic test_run_protect();
      tick(140, 1'b1, 16'd1, 1'b0, 1'b0);
      idle_tick();
      tick(16, 1'b1, 16'h5555, 1'b0, 1'b0);
      checks++; if (CoeffBus[31:16] !== 16'h0000) begin errors++; $display("FAIL rp_coeff1 got=%h exp=0000", CoeffBus[31:16]); end
      checks++; if (WrErr !== 1'b1) begin errors++; $display("FAIL rp_wrerr got=%b exp=1", WrErr); end
      tick(140, 1'b1, 16'd1, 1'b0, 1'b0);
      checks++; if ({Start, Busy} !== 2'b01) begin errors++; $display("FAIL rp_nostart got=%b%b exp=01", Start, Busy); end
      // Done together with a data write: still RUN, so dropped with error
      tick(20, 1'b1, 16'h7777, 1'b0, 1'b1);
      checks++; if ({Busy, WrErr, CoeffBus[47:32]} !== {2'b01, 16'h0000}) begin errors++; $display("FAIL rp_done_wr busy=%b err=%b c2=%h exp=0/1/0000", Busy, WrErr, CoeffBus[47:32]); end
      tick(140, 1'b1, 16'd1, 1'b0, 1'b0);
      checks++; if ({Start, WrErr} !== 2'b10) begin errors++; $display("FAIL rp_clear got=%b%b exp=10", Start, WrErr); end
      idle_tick(); idle_tick();
      tick(0, 1'b0, 16'd0, 1'b0, 1'b1);
   endtask

   task automatic test_decode();
      tick(13, 1'b1, 16'hFFFF, 1'b0, 1'b0);
      tick(252, 1'b1, 16'hFFFF, 1'b0, 1'b0);
      tick(144, 1'b1, 16'hFFFF, 1'b0, 1'b0);
      checks++; if (CoeffBus !== {{(N-1)*DW{1'b0}}, 16'h1234}) begin errors++; $display("FAIL dec_coeff got=%h", CoeffBus); end
      checks++; if ({Offset, Entrada} !== {16'h0000, 16'hABCD}) begin errors++; $display("FAIL dec_off_in got=%h/%h exp=0000/abcd", Offset, Entrada); end
      checks++; if ({WrErr, Busy} !== 2'b00) begin errors++; $display("FAIL dec_flags got=%b%b exp=00", WrErr, Busy); end
   endtask

   task automatic test_readback();
`ifdef NRB_READBACK_EN
      tick(12, 1'b0, 16'd0, 1'b1, 1'b0);
      checks++; if ({ReadValid, ReadData} !== {1'b1, 16'h1234}) begin errors++; $display("FAIL rb_coeff0 v=%b got=%h exp=1/1234", ReadValid, ReadData); end
      idle_tick();
      checks++; if (ReadValid !== 1'b0) begin errors++; $display("FAIL rb_pulse got=%b exp=0", ReadValid); end
      tick(140, 1'b1, 16'd1, 1'b0, 1'b0);
      idle_tick();
      tick(0, 1'b0, 16'd0, 1'b0, 1'b1);
      tick(144, 1'b0, 16'd0, 1'b1, 1'b0);
      checks++; if (ReadData !== 16'h0002) begin errors++; $display("FAIL rb_status1 got=%h exp=0002", ReadData); end
      tick(144, 1'b0, 16'd0, 1'b1, 1'b0);
      checks++; if (ReadData !== 16'h0000) begin errors++; $display("FAIL rb_status2 got=%h exp=0000", ReadData); end
      tick(300, 1'b0, 16'd0, 1'b1, 1'b0);
      checks++; if ({ReadValid, ReadData} !== {1'b1, 16'h0000}) begin errors++; $display("FAIL rb_unmapped v=%b got=%h exp=1/0000", ReadValid, ReadData); end
`else
      tick(12, 1'b0, 16'd0, 1'b1, 1'b0);
      checks++; if ({ReadValid, ReadData} !== 17'd0) begin errors++; $display("FAIL rb_off v=%b got=%h exp=0/0000", ReadValid, ReadData); end
      tick(144, 1'b0, 16'd0, 1'b1, 1'b0);
      checks++; if ({ReadValid, ReadData} !== 17'd0) begin errors++; $display("FAIL rb_off_status v=%b got=%h exp=0/0000", ReadValid, ReadData); end
`endif
   endtask

   task automatic test_reset_mid_run();
      tick(92, 1'b1, 16'h4242, 1'b0, 1'b0);
      tick(140, 1'b1, 16'd1, 1'b0, 1'b0);
      idle_tick(); idle_tick();
      Reset_n = 1'b0;
      idle_tick();
      Reset_n = 1'b1;
      checks++; if ({Start, Busy, WrErr} !== 3'd0) begin errors++; $display("FAIL rmr_flags got=%b%b%b exp=000", Start, Busy, WrErr); end
      checks++; if (CoeffBus !== '0 || Offset !== 16'd0 || Entrada !== 16'd0) begin errors++; $display("FAIL rmr_regs off=%h in=%h exp=0", Offset, Entrada); end
      tick(0, 1'b0, 16'd0, 1'b0, 1'b1);
      idle_tick();
      checks++; if ({Start, Busy} !== 2'b00) begin errors++; $display("FAIL rmr_late_done got=%b%b exp=00", Start, Busy); end
   endtask

   task automatic test_random();
      int sel, a;
      bit we, rd, dn;
      logic [DW-1:0] wd;
      logic [N*DW-1:0] exp_bus;
      for (int it = 0; it < 500; it++) begin
         sel = int'($urandom_range(0, 9));
         case (sel)
            0, 1, 2, 3: a = 12 + 4 * int'($urandom_range(0, N - 1));
            4: a = 92;
            5: a = 96;
            6: a = 140;
            7: a = 144;
            8: a = 12 + 4 * int'($urandom_range(0, N + 1)) + int'($urandom_range(1, 3));
            default: a = int'($urandom_range(100, 511));
         endcase
         we = ($urandom_range(0, 2) != 0);
         rd = ($urandom_range(0, 2) == 0);
         dn = ($urandom_range(0, 5) == 0);
         wd = 16'($urandom);
         if (sel == 6 && $urandom_range(0, 3) != 0) wd[0] = 1'b1;
         tick(a, we, wd, rd, dn);
         for (int i = 0; i < N; i++) exp_bus[i*DW +: DW] = m_coeff[i];
         checks++; if (CoeffBus !== exp_bus) begin errors++; $display("FAIL rnd_coeff it=%0d got=%h exp=%h", it, CoeffBus, exp_bus); end
         checks++; if ({Offset, Entrada} !== {m_offset, m_entrada}) begin errors++; $display("FAIL rnd_off_in it=%0d got=%h/%h exp=%h/%h", it, Offset, Entrada, m_offset, m_entrada); end
         checks++; if ({Start, Busy, WrErr} !== {m_start, m_busy, m_err}) begin errors++; $display("FAIL rnd_flags it=%0d got=%b%b%b exp=%b%b%b", it, Start, Busy, WrErr, m_start, m_busy, m_err); end
         checks++; if ({ReadValid, ReadData} !== {m_rvalid, m_rdata}) begin errors++; $display("FAIL rnd_read it=%0d got=%b/%h exp=%b/%h", it, ReadValid, ReadData, m_rvalid, m_rdata); end
      end
   endtask

   initial begin
      #2;
      test_reset();
      test_writes();
      test_start_done();
      test_run_protect();
      test_decode();
      test_readback();
      test_reset_mid_run();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
